// File: rtl/rf_access_arbiter.sv
// Two-port arbiter in front of the register file: clears x1..x31 after reset, then
// grants one core/debug transaction per cycle. Optional macro RF_BYPASS_EN forwards same-transaction writes.
module rf_access_arbiter #(
  parameter int ARB_MODE   = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid,
  input  logic        p1_valid,
  output logic        p0_ready,
  output logic        p1_ready,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [4:0]  p0_ra1,
  input  logic [4:0]  p0_ra2,
  input  logic [4:0]  p1_ra1,
  input  logic [4:0]  p1_ra2,
  input  logic [4:0]  p0_wa,
  input  logic [4:0]  p1_wa,
  input  logic [31:0] p0_wd,
  input  logic [31:0] p1_wd,
  output logic        p0_rsp_valid,
  output logic        p1_rsp_valid,
  output logic [31:0] rsp_rd1,
  output logic [31:0] rsp_rd2,
  output logic        init_busy,
  output logic [4:0]  rf_A1,
  output logic [4:0]  rf_A2,
  output logic [4:0]  rf_A3,
  output logic [31:0] rf_WD,
  output logic        rf_WE,
  input  logic [31:0] rf_RD1,
  input  logic [31:0] rf_RD2
);

  // Handshake: a transaction on port x is accepted in any cycle where px_valid && px_ready;
  // its response is a one-cycle px_rsp_valid pulse in the next cycle.
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        rr_last_q;
  logic        init_busy_q;
  logic        rsp0_q, rsp1_q;
  logic [4:0]  a1_q, a2_q, a3_q;
  logic [31:0] wd_q;

  logic        run, tie, gnt0, gnt1, rsp_any;
  logic [4:0]  a1_d, a2_d, a3_d;
  logic [31:0] wd_d;
  logic        we_d;
  logic [31:0] rd1_src, rd2_src;

  // rr_last_q = 1 means port 1 won the last contended cycle, so port 0 wins the next tie.
  assign run  = rst_n && (state_q == ST_RUN);
  assign tie  = p0_valid && p1_valid;
  assign gnt0 = run && p0_valid && (!p1_valid || (ARB_MODE == 0) || rr_last_q);
  assign gnt1 = run && p1_valid && !gnt0;

  assign p0_ready  = gnt0;
  assign p1_ready  = gnt1;
  assign init_busy = init_busy_q;

  always_comb begin
    a1_d = a1_q;
    a2_d = a2_q;
    a3_d = a3_q;
    wd_d = wd_q;
    we_d = 1'b0;
    if (rst_n && (state_q == ST_INIT)) begin
      a1_d = '0;
      a2_d = '0;
      a3_d = cnt_q;
      wd_d = '0;
      we_d = 1'b1;
    end else if (gnt0) begin
      a1_d = p0_ra1;
      a2_d = p0_ra2;
      a3_d = p0_wa;
      wd_d = p0_wd;
      we_d = p0_we && (p0_wa != 5'd0);
    end else if (gnt1) begin
      a1_d = p1_ra1;
      a2_d = p1_ra2;
      a3_d = p1_wa;
      wd_d = p1_wd;
      we_d = p1_we && (p1_wa != 5'd0);
    end
  end

  assign rf_A1 = a1_d;
  assign rf_A2 = a2_d;
  assign rf_A3 = a3_d;
  assign rf_WD = wd_d;
  assign rf_WE = we_d;

  // Idle cycles re-drive the last addresses so the register file inputs do not toggle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a1_q <= '0;
      a2_q <= '0;
      a3_q <= '0;
      wd_q <= '0;
    end else begin
      a1_q <= a1_d;
      a2_q <= a2_d;
      a3_q <= a3_d;
      wd_q <= wd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      cnt_q       <= 5'd1;
      init_busy_q <= (INIT_CLEAR != 0);
      rr_last_q   <= 1'b1;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
    end else begin
      rsp0_q <= gnt0;
      rsp1_q <= gnt1;
      case (state_q)
        ST_INIT: begin
          if (cnt_q == 5'd31) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
            cnt_q       <= 5'd1;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ST_RUN: begin
          if (tie && (gnt0 || gnt1)) rr_last_q <= gnt1;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

`ifdef RF_BYPASS_EN
  logic        byp_we_q;
  logic [4:0]  byp_wa_q, byp_ra1_q, byp_ra2_q;
  logic [31:0] byp_wd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_we_q  <= 1'b0;
      byp_wa_q  <= '0;
      byp_ra1_q <= '0;
      byp_ra2_q <= '0;
      byp_wd_q  <= '0;
    end else begin
      byp_we_q  <= (gnt0 || gnt1) && we_d;
      byp_wa_q  <= a3_d;
      byp_ra1_q <= a1_d;
      byp_ra2_q <= a2_d;
      byp_wd_q  <= wd_d;
    end
  end

  // byp_we_q already excludes x0, so a match here is always a real write.
  assign rd1_src = (byp_we_q && (byp_wa_q == byp_ra1_q)) ? byp_wd_q : rf_RD1;
  assign rd2_src = (byp_we_q && (byp_wa_q == byp_ra2_q)) ? byp_wd_q : rf_RD2;
`else
  assign rd1_src = rf_RD1;
  assign rd2_src = rf_RD2;
`endif

  // Responses are squashed while reset is held so nothing leaks out of a reset cycle.
  assign p0_rsp_valid = rsp0_q && rst_n;
  assign p1_rsp_valid = rsp1_q && rst_n;
  assign rsp_any      = p0_rsp_valid || p1_rsp_valid;
  assign rsp_rd1      = rsp_any ? rd1_src : '0;
  assign rsp_rd2      = rsp_any ? rd2_src : '0;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural register file; a second
// fixed-priority, no-clear instance shares the request inputs.
module tb_rf_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p1_valid, p0_we, p1_we;
  logic [4:0]  p0_ra1, p0_ra2, p1_ra1, p1_ra2, p0_wa, p1_wa;
  logic [31:0] p0_wd, p1_wd;
  logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, init_busy;
  logic [31:0] rsp_rd1, rsp_rd2;
  logic [4:0]  rf_A1, rf_A2, rf_A3;
  logic [31:0] rf_WD, rf_RD1, rf_RD2;
  logic        rf_WE;

  logic        fp_p0_ready, fp_p1_ready, fp_p0_rsp, fp_p1_rsp, fp_init_busy, fp_we;
  logic [31:0] fp_rd1, fp_rd2, fp_wd;
  logic [4:0]  fp_a1, fp_a2, fp_a3;
  logic [31:0] zero32 = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rf_access_arbiter #(.ARB_MODE(1), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p1_valid(p1_valid), .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_we(p0_we), .p1_we(p1_we),
    .p0_ra1(p0_ra1), .p0_ra2(p0_ra2), .p1_ra1(p1_ra1), .p1_ra2(p1_ra2),
    .p0_wa(p0_wa), .p1_wa(p1_wa), .p0_wd(p0_wd), .p1_wd(p1_wd),
    .p0_rsp_valid(p0_rsp_valid), .p1_rsp_valid(p1_rsp_valid),
    .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2), .init_busy(init_busy),
    .rf_A1(rf_A1), .rf_A2(rf_A2), .rf_A3(rf_A3), .rf_WD(rf_WD), .rf_WE(rf_WE),
    .rf_RD1(rf_RD1), .rf_RD2(rf_RD2)
  );

  rf_access_arbiter #(.ARB_MODE(0), .INIT_CLEAR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p1_valid(p1_valid), .p0_ready(fp_p0_ready), .p1_ready(fp_p1_ready),
    .p0_we(p0_we), .p1_we(p1_we),
    .p0_ra1(p0_ra1), .p0_ra2(p0_ra2), .p1_ra1(p1_ra1), .p1_ra2(p1_ra2),
    .p0_wa(p0_wa), .p1_wa(p1_wa), .p0_wd(p0_wd), .p1_wd(p1_wd),
    .p0_rsp_valid(fp_p0_rsp), .p1_rsp_valid(fp_p1_rsp),
    .rsp_rd1(fp_rd1), .rsp_rd2(fp_rd2), .init_busy(fp_init_busy),
    .rf_A1(fp_a1), .rf_A2(fp_a2), .rf_A3(fp_a3), .rf_WD(fp_wd), .rf_WE(fp_we),
    .rf_RD1(zero32), .rf_RD2(zero32)
  );

  // Behavioural register file: registered read, x0 reads zero, read-before-write.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    rf_RD1 <= (rf_A1 == 5'd0) ? 32'd0 : mem[rf_A1];
    rf_RD2 <= (rf_A2 == 5'd0) ? 32'd0 : mem[rf_A2];
    if (rf_WE && (rf_A3 != 5'd0)) mem[rf_A3] <= rf_WD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_p0(input logic v, input logic we, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic [4:0] wa, input logic [31:0] wd);
    p0_valid = v; p0_we = we; p0_ra1 = ra1; p0_ra2 = ra2; p0_wa = wa; p0_wd = wd;
  endtask

  task automatic set_p1(input logic v, input logic we, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic [4:0] wa, input logic [31:0] wd);
    p1_valid = v; p1_we = we; p1_ra1 = ra1; p1_ra2 = ra2; p1_wa = wa; p1_wd = wd;
  endtask

  task automatic init_sweep(input string tag);
    for (int i = 1; i <= 31; i++) begin
      settle();
      check({tag, "_busy"}, {31'd0, init_busy}, 32'd1);
      check({tag, "_we"}, {31'd0, rf_WE}, 32'd1);
      check({tag, "_a3"}, {27'd0, rf_A3}, i);
      check({tag, "_wd"}, rf_WD, 32'd0);
      check({tag, "_p0_ready"}, {31'd0, p0_ready}, 32'd0);
      next_cycle();
    end
  endtask

  logic [31:0] exp_rd1;

  initial begin
    rst_n = 1'b0;
    set_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    set_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) next_cycle();

    // Reset state
    settle();
    check("rst_busy", {31'd0, init_busy}, 32'd1);
    check("rst_we", {31'd0, rf_WE}, 32'd0);
    check("rst_rsp0", {31'd0, p0_rsp_valid}, 32'd0);
    check("rst_rd1", rsp_rd1, 32'd0);
    check("rst_fp_busy", {31'd0, fp_init_busy}, 32'd0);

    // Clear sequence with p0 held valid, then read x5
    rst_n = 1'b1;
    set_p0(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
    settle();
    check("fp_ready_no_init", {31'd0, fp_p0_ready}, 32'd1);
    init_sweep("init");
    settle();
    check("run_p0_ready", {31'd0, p0_ready}, 32'd1);
    check("run_busy", {31'd0, init_busy}, 32'd0);
    next_cycle();
    set_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    settle();
    check("x5_rsp0", {31'd0, p0_rsp_valid}, 32'd1);
    check("x5_rd1", rsp_rd1, 32'd0);
    check("x5_rsp1", {31'd0, p1_rsp_valid}, 32'd0);

    // Write x3 then read it back next cycle
    next_cycle();
    set_p0(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 32'hDEADBEEF);
    settle();
    check("wr3_we", {31'd0, rf_WE}, 32'd1);
    check("wr3_a3", {27'd0, rf_A3}, 32'd3);
    check("wr3_wd", rf_WD, 32'hDEADBEEF);
    next_cycle();
    set_p0(1'b1, 1'b0, 5'd3, 5'd0, 5'd3, 32'd0);
    settle();
    check("wr3_ack", {31'd0, p0_rsp_valid}, 32'd1);
    check("rd3_we", {31'd0, rf_WE}, 32'd0);
    next_cycle();
    set_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    settle();
    check("rd3_rsp0", {31'd0, p0_rsp_valid}, 32'd1);
    check("rd3_rd1", rsp_rd1, 32'hDEADBEEF);
    check("rd3_rsp1", {31'd0, p1_rsp_valid}, 32'd0);
    check("idle_hold_a1", {27'd0, rf_A1}, 32'd3);
    check("idle_we", {31'd0, rf_WE}, 32'd0);

    // Contention: round-robin on dut, fixed priority on dut_fp
    next_cycle();
    set_p0(1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0);
    set_p1(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("rr_p0_ready", {31'd0, p0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_p1_ready", {31'd0, p1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check("fp_p0_ready", {31'd0, fp_p0_ready}, 32'd1);
      check("fp_p1_ready", {31'd0, fp_p1_ready}, 32'd0);
      if (k > 0) begin
        check("rr_rsp0", {31'd0, p0_rsp_valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        check("rr_rsp1", {31'd0, p1_rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
        check("rr_rd1", rsp_rd1, (k % 2 == 1) ? 32'hDEADBEEF : 32'd0);
      end
      next_cycle();
    end
    set_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    set_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    settle();
    check("rr_last_rsp1", {31'd0, p1_rsp_valid}, 32'd1);
    check("rr_last_rsp0", {31'd0, p0_rsp_valid}, 32'd0);

    // p1 writes x0: suppressed, still acknowledged, x0 reads zero
    next_cycle();
    set_p1(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h12345678);
    settle();
    check("x0_ready", {31'd0, p1_ready}, 32'd1);
    check("x0_we", {31'd0, rf_WE}, 32'd0);
    next_cycle();
    set_p1(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    settle();
    check("x0_ack", {31'd0, p1_rsp_valid}, 32'd1);
    next_cycle();
    set_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    settle();
    check("x0_rsp1", {31'd0, p1_rsp_valid}, 32'd1);
    check("x0_rd1", rsp_rd1, 32'd0);
    next_cycle();
    settle();
    check("idle_rd_zero", rsp_rd1, 32'd0);
    check("idle_rsp1", {31'd0, p1_rsp_valid}, 32'd0);

    // Same-transaction read and write of x7
    set_p0(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 32'h00000011);
    next_cycle();
    set_p0(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 32'hA5A5A5A5);
    settle();
    check("rw7_ack", {31'd0, p0_rsp_valid}, 32'd1);
    next_cycle();
    set_p0(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'd0);
`ifdef RF_BYPASS_EN
    exp_rd1 = 32'hA5A5A5A5;
`else
    exp_rd1 = 32'h00000011;
`endif
    settle();
    check("rw7_rsp0", {31'd0, p0_rsp_valid}, 32'd1);
    check("rw7_rd1", rsp_rd1, exp_rd1);
    check("rw7_rd2", rsp_rd2, 32'hDEADBEEF);
    next_cycle();
    set_p0(1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0);
    settle();
    check("rd7_rd1", rsp_rd1, 32'hA5A5A5A5);

    // Reset in the cycle after a grant of a read of x3
    next_cycle();
    rst_n = 1'b0;
    set_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    settle();
    check("mrst_rsp0", {31'd0, p0_rsp_valid}, 32'd0);
    check("mrst_we", {31'd0, rf_WE}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    settle();
    check("mrst_rsp0_after", {31'd0, p0_rsp_valid}, 32'd0);
    set_p0(1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0);
    init_sweep("reinit");
    settle();
    check("reinit_ready", {31'd0, p0_ready}, 32'd1);
    next_cycle();
    set_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    settle();
    check("reinit_rsp0", {31'd0, p0_rsp_valid}, 32'd1);
    check("reinit_x3_cleared", rsp_rd1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
